sprite_fetch_ctrl: RTL and testbench

- Per-pixel scheduler for the five 32x32 sprite ROMs: pac-man cut, pac-man full, and the red, blue and green ghosts.
- Each ROM is 1024 x 24-bit with a registered 1-cycle read.
- Computes hits and ROM addresses from the draw position, sequences the 1-cycle ROM latency, and composites by priority and transparency.
- Runs a pac-man mouth animation FSM. Sits between the VGA draw counters and the color mapper.

---
 rtl/sprite_fetch_ctrl_if.sv | 45 ++++
 rtl/sprite_fetch_ctrl.sv | 152 +++++++++++++++
 tb/tb_sprite_fetch_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_fetch_ctrl_if.sv
// Pixel, sprite-position, ROM and result signals of sprite_fetch_ctrl.
// The master side is the draw/ROM environment; the slave side is the controller.
interface sprite_fetch_ctrl_if;
   logic        frame_start;
   logic        px_valid_in;
   logic [9:0]  DrawX;
   logic [9:0]  DrawY;
   logic [9:0]  pac_x;
   logic [9:0]  pac_y;
   logic [1:0]  pac_dir;
   logic        pac_moving;
   logic [9:0]  red_x;
   logic [9:0]  red_y;
   logic [9:0]  blue_x;
   logic [9:0]  blue_y;
   logic [9:0]  green_x;
   logic [9:0]  green_y;
   logic        frightened;
   logic [9:0]  pac_addr;
   logic [9:0]  red_addr;
   logic [9:0]  blue_addr;
   logic [9:0]  green_addr;
   logic [23:0] pac_cut_data;
   logic [23:0] pac_full_data;
   logic [23:0] red_data;
   logic [23:0] blue_data;
   logic [23:0] green_data;
   logic        px_valid_out;
   logic        sprite_hit;
   logic [23:0] sprite_rgb;

   modport master (
      output frame_start, px_valid_in, DrawX, DrawY, pac_x, pac_y, pac_dir, pac_moving,
             red_x, red_y, blue_x, blue_y, green_x, green_y, frightened,
             pac_cut_data, pac_full_data, red_data, blue_data, green_data,
      input  pac_addr, red_addr, blue_addr, green_addr, px_valid_out, sprite_hit, sprite_rgb
   );

   modport slave (
      input  frame_start, px_valid_in, DrawX, DrawY, pac_x, pac_y, pac_dir, pac_moving,
             red_x, red_y, blue_x, blue_y, green_x, green_y, frightened,
             pac_cut_data, pac_full_data, red_data, blue_data, green_data,
      output pac_addr, red_addr, blue_addr, green_addr, px_valid_out, sprite_hit, sprite_rgb
   );
endinterface

// File: rtl/sprite_fetch_ctrl.sv
// Per-pixel sprite ROM address generation, 2-cycle composite pipeline and pac-man mouth animation.
// Optional macro GHOST_FRIGHT_EN: frightened ghosts draw in a fixed blue instead of ROM color.
module sprite_fetch_ctrl #(
   parameter int unsigned SPRITE_W    = 32,
   parameter int unsigned ANIM_FRAMES = 8,
   parameter logic [23:0] TRANSPARENT = 24'h000000
) (
   input logic              Clk,
   input logic              Reset_n,
   sprite_fetch_ctrl_if.slave bus
);
   localparam int unsigned CW    = 11;
   localparam int unsigned CNT_W = 8;

   typedef enum logic {MOUTH_OPEN = 1'b0, MOUTH_CLOSED = 1'b1} anim_t;

   anim_t              anim_state;
   logic [CNT_W-1:0]   anim_cnt;
   logic               v1;
   logic               hit_r1, hit_b1, hit_g1, hit_p1;
   logic               closed1;
   logic               hit_r, hit_b, hit_g, hit_p;
   logic [9:0]         rc_r, rc_b, rc_g, rc_p;
   logic [4:0]         pr, pc;
   logic [9:0]         pac_a;
   logic               win_c;
   logic               ghost_c;
   logic [23:0]        rgb_c;
   logic [23:0]        pac_word;

   // Unsigned 11-bit box test so sprites near the right edge never wrap to x=0.
   function automatic logic in_box(input logic [9:0] px, py, sx, sy);
      logic [CW-1:0] x, y, bx, by;
      x  = CW'(px);
      y  = CW'(py);
      bx = CW'(sx);
      by = CW'(sy);
      return (x >= bx) && (x < bx + CW'(SPRITE_W)) && (y >= by) && (y < by + CW'(SPRITE_W));
   endfunction

   function automatic logic [9:0] rc_of(input logic [9:0] px, py, sx, sy);
      return {5'(py - sy), 5'(px - sx)};
   endfunction

   assign hit_r = in_box(bus.DrawX, bus.DrawY, bus.red_x,   bus.red_y);
   assign hit_b = in_box(bus.DrawX, bus.DrawY, bus.blue_x,  bus.blue_y);
   assign hit_g = in_box(bus.DrawX, bus.DrawY, bus.green_x, bus.green_y);
   assign hit_p = in_box(bus.DrawX, bus.DrawY, bus.pac_x,   bus.pac_y);

   assign rc_r = rc_of(bus.DrawX, bus.DrawY, bus.red_x,   bus.red_y);
   assign rc_b = rc_of(bus.DrawX, bus.DrawY, bus.blue_x,  bus.blue_y);
   assign rc_g = rc_of(bus.DrawX, bus.DrawY, bus.green_x, bus.green_y);
   assign rc_p = rc_of(bus.DrawX, bus.DrawY, bus.pac_x,   bus.pac_y);
   assign pr   = rc_p[9:5];
   assign pc   = rc_p[4:0];

   // Pac-man ROM is drawn facing right; other directions mirror/transpose the lookup.
   always_comb begin
      pac_a = {pr, pc};
      unique case (bus.pac_dir)
         2'd0: pac_a = {pr, pc};
         2'd1: pac_a = {pr, ~pc};
         2'd2: pac_a = {pc, pr};
         2'd3: pac_a = {~pc, pr};
         default: pac_a = {pr, pc};
      endcase
   end

   assign bus.pac_addr   = hit_p ? pac_a : 10'd0;
   assign bus.red_addr   = hit_r ? rc_r  : 10'd0;
   assign bus.blue_addr  = hit_b ? rc_b  : 10'd0;
   assign bus.green_addr = hit_g ? rc_g  : 10'd0;

   // Mouth animation: toggle every ANIM_FRAMES frames while pac-man moves.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         anim_state <= MOUTH_OPEN;
         anim_cnt   <= '0;
      end else if (bus.frame_start && bus.pac_moving) begin
         if (anim_cnt == CNT_W'(ANIM_FRAMES - 1)) begin
            anim_cnt   <= '0;
            anim_state <= (anim_state == MOUTH_OPEN) ? MOUTH_CLOSED : MOUTH_OPEN;
         end else begin
            anim_cnt <= anim_cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         v1      <= 1'b0;
         hit_r1  <= 1'b0;
         hit_b1  <= 1'b0;
         hit_g1  <= 1'b0;
         hit_p1  <= 1'b0;
         closed1 <= 1'b0;
      end else begin
         v1      <= bus.px_valid_in;
         hit_r1  <= hit_r;
         hit_b1  <= hit_b;
         hit_g1  <= hit_g;
         hit_p1  <= hit_p;
         closed1 <= (anim_state == MOUTH_CLOSED);
      end
   end

`ifdef GHOST_FRIGHT_EN
   logic fright1;
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) fright1 <= 1'b0;
      else          fright1 <= bus.frightened;
   end
`else
   logic fright_unused;
   assign fright_unused = bus.frightened;
`endif

   assign pac_word = closed1 ? bus.pac_full_data : bus.pac_cut_data;

   // Priority composite: red > blue > green > pac-man, skipping transparent words.
   always_comb begin
      win_c   = 1'b0;
      ghost_c = 1'b0;
      rgb_c   = 24'h000000;
      if (v1) begin
         if (hit_r1 && bus.red_data != TRANSPARENT) begin
            win_c = 1'b1; ghost_c = 1'b1; rgb_c = bus.red_data;
         end else if (hit_b1 && bus.blue_data != TRANSPARENT) begin
            win_c = 1'b1; ghost_c = 1'b1; rgb_c = bus.blue_data;
         end else if (hit_g1 && bus.green_data != TRANSPARENT) begin
            win_c = 1'b1; ghost_c = 1'b1; rgb_c = bus.green_data;
         end else if (hit_p1 && pac_word != TRANSPARENT) begin
            win_c = 1'b1; rgb_c = pac_word;
         end
      end
`ifdef GHOST_FRIGHT_EN
      if (ghost_c && fright1) rgb_c = 24'h2121FF;
`endif
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         bus.px_valid_out <= 1'b0;
         bus.sprite_hit   <= 1'b0;
         bus.sprite_rgb   <= 24'h000000;
      end else begin
         bus.px_valid_out <= v1;
         bus.sprite_hit   <= win_c;
         bus.sprite_rgb   <= rgb_c;
      end
   end
endmodule

// File: tb/tb_sprite_fetch_ctrl.sv
// Directed and randomized bench for sprite_fetch_ctrl against a pixel-level reference model.
module tb_sprite_fetch_ctrl;
   localparam int ANIM = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   sprite_fetch_ctrl_if bus();

   sprite_fetch_ctrl #(.SPRITE_W(32), .ANIM_FRAMES(ANIM), .TRANSPARENT(24'h000000)) dut (
      .Clk(clk), .Reset_n(rst_n), .bus(bus)
   );

   logic [23:0] rom_pc [1024];
   logic [23:0] rom_pf [1024];
   logic [23:0] rom_r  [1024];
   logic [23:0] rom_b  [1024];
   logic [23:0] rom_g  [1024];

   // Registered 1-cycle ROM reads
   always_ff @(posedge clk) begin
      bus.pac_cut_data  <= rom_pc[bus.pac_addr];
      bus.pac_full_data <= rom_pf[bus.pac_addr];
      bus.red_data      <= rom_r[bus.red_addr];
      bus.blue_data     <= rom_b[bus.blue_addr];
      bus.green_data    <= rom_g[bus.green_addr];
   end

   typedef struct {bit v; bit h; logic [23:0] rgb;} exp_t;
   exp_t q[$];
   exp_t e0 = '{v: 1'b0, h: 1'b0, rgb: 24'h0};
   int   m_cnt;
   bit   m_closed;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_hit(int px, int py, int sx, int sy);
      return px >= sx && px < sx + 32 && py >= sy && py < sy + 32;
   endfunction

   function automatic int m_addr(int px, int py, int sx, int sy, int dir);
      int r = py - sy;
      int c = px - sx;
      if (!m_hit(px, py, sx, sy)) return 0;
      case (dir)
         0: return r * 32 + c;
         1: return r * 32 + (31 - c);
         2: return c * 32 + r;
         default: return (31 - c) * 32 + r;
      endcase
   endfunction

   function automatic exp_t m_pixel(bit pv);
      exp_t e = '{v: pv, h: 1'b0, rgb: 24'h0};
      int px = int'(bus.DrawX);
      int py = int'(bus.DrawY);
      int sx[4] = '{int'(bus.red_x), int'(bus.blue_x), int'(bus.green_x), int'(bus.pac_x)};
      int sy[4] = '{int'(bus.red_y), int'(bus.blue_y), int'(bus.green_y), int'(bus.pac_y)};
      if (!pv) return e;
      for (int i = 0; i < 4; i++) begin
         if (m_hit(px, py, sx[i], sy[i])) begin
            logic [23:0] w;
            int a = m_addr(px, py, sx[i], sy[i], (i == 3) ? int'(bus.pac_dir) : 0);
            case (i)
               0: w = rom_r[a];
               1: w = rom_b[a];
               2: w = rom_g[a];
               default: w = m_closed ? rom_pf[a] : rom_pc[a];
            endcase
            if (w != 24'h0) begin
               e.h = 1'b1;
               e.rgb = w;
`ifdef GHOST_FRIGHT_EN
               if (i < 3 && bus.frightened) e.rgb = 24'h2121FF;
`endif
               return e;
            end
         end
      end
      return e;
   endfunction

   // One clock cycle: drive pixel, check addresses and 2-cycle-old result, advance the model.
   task automatic cyc(input bit fs, input bit pv, input int dx, input int dy);
      exp_t old;
      int px, py;
      bus.frame_start = fs;
      bus.px_valid_in = pv;
      bus.DrawX = 10'(dx);
      bus.DrawY = 10'(dy);
      #1;
      px = int'(bus.DrawX);
      py = int'(bus.DrawY);
      check("pac_addr",   32'(bus.pac_addr),   32'(m_addr(px, py, int'(bus.pac_x), int'(bus.pac_y), int'(bus.pac_dir))));
      check("red_addr",   32'(bus.red_addr),   32'(m_addr(px, py, int'(bus.red_x), int'(bus.red_y), 0)));
      check("blue_addr",  32'(bus.blue_addr),  32'(m_addr(px, py, int'(bus.blue_x), int'(bus.blue_y), 0)));
      check("green_addr", 32'(bus.green_addr), 32'(m_addr(px, py, int'(bus.green_x), int'(bus.green_y), 0)));
      old = q.pop_front();
      check("px_valid_out", 32'(bus.px_valid_out), 32'(old.v));
      check("sprite_hit",   32'(bus.sprite_hit),   32'(old.h));
      check("sprite_rgb",   32'(bus.sprite_rgb),   32'(old.rgb));
      q.push_back(m_pixel(pv));
      if (fs && bus.pac_moving) begin
         m_cnt++;
         if (m_cnt == ANIM) begin
            m_cnt = 0;
            m_closed = !m_closed;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      q = {};
      q.push_back(e0);
      q.push_back(e0);
      m_cnt = 0;
      m_closed = 1'b0;
   endtask

   task automatic place(input int px, input int py, input int rx, input int ry,
                        input int bx, input int by, input int gx, input int gy);
      bus.pac_x = 10'(px);   bus.pac_y = 10'(py);
      bus.red_x = 10'(rx);   bus.red_y = 10'(ry);
      bus.blue_x = 10'(bx);  bus.blue_y = 10'(by);
      bus.green_x = 10'(gx); bus.green_y = 10'(gy);
   endtask

   initial begin
      rst_n = 1'b0;
      bus.frame_start = 1'b0; bus.px_valid_in = 1'b0;
      bus.DrawX = '0; bus.DrawY = '0; bus.pac_dir = 2'd0;
      bus.pac_moving = 1'b0; bus.frightened = 1'b0;
      place(100, 100, 400, 300, 450, 300, 500, 300);
      for (int i = 0; i < 1024; i++) begin
         rom_pc[i] = ($urandom_range(0, 3) == 0) ? 24'h0 : 24'($urandom);
         rom_pf[i] = ($urandom_range(0, 3) == 0) ? 24'h0 : 24'($urandom);
         rom_r[i]  = ($urandom_range(0, 3) == 0) ? 24'h0 : 24'($urandom);
         rom_b[i]  = ($urandom_range(0, 3) == 0) ? 24'h0 : 24'($urandom);
         rom_g[i]  = ($urandom_range(0, 3) == 0) ? 24'h0 : 24'($urandom);
      end
      rom_pc[10'h065] = 24'h123456;
      rom_pf[10'h065] = 24'h654321;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(bus.px_valid_out), 32'd0);
      check("rst_hit",   32'(bus.sprite_hit),   32'd0);
      check("rst_rgb",   32'(bus.sprite_rgb),   32'd0);
      rst_n = 1'b1;
      model_reset();

      // Latency and direction addressing
      bus.DrawX = 10'd105; bus.DrawY = 10'd103;
      bus.pac_dir = 2'd1; #1; check("dir1_addr", 32'(bus.pac_addr), 32'h07A);
      bus.pac_dir = 2'd2; #1; check("dir2_addr", 32'(bus.pac_addr), 32'h0A3);
      bus.pac_dir = 2'd3; #1; check("dir3_addr", 32'(bus.pac_addr), 32'h343);
      bus.pac_dir = 2'd0; #1; check("dir0_addr", 32'(bus.pac_addr), 32'h065);
      cyc(0, 1, 105, 103);
      check("lat_n1_valid", 32'(bus.px_valid_out), 32'd0);
      cyc(0, 0, 0, 0);
      check("lat_valid", 32'(bus.px_valid_out), 32'd1);
      check("lat_rgb",   32'(bus.sprite_rgb),   32'h123456);

      // Priority and transparency
      place(500, 400, 200, 200, 200, 200, 560, 400);
      rom_r[{5'd10, 5'd10}] = 24'h000000;
      rom_b[{5'd10, 5'd10}] = 24'hFF00FF;
      cyc(0, 1, 210, 210);
      cyc(0, 0, 0, 0);
      check("prio_blue", 32'(bus.sprite_rgb), 32'hFF00FF);
      rom_r[{5'd10, 5'd10}] = 24'hFF0000;
      cyc(0, 1, 210, 210);
      cyc(0, 0, 0, 0);
      check("prio_red", 32'(bus.sprite_rgb), 32'hFF0000);

      // Mouth animation
      place(100, 100, 400, 300, 450, 300, 500, 300);
      bus.pac_moving = 1'b1;
      repeat (ANIM) cyc(1, 0, 0, 0);
      cyc(0, 1, 105, 103);
      cyc(0, 0, 0, 0);
      check("anim_closed", 32'(bus.sprite_rgb), 32'h654321);
      bus.pac_moving = 1'b0;
      repeat (20) cyc(1, 0, 0, 0);
      cyc(0, 1, 105, 103);
      cyc(0, 0, 0, 0);
      check("anim_hold", 32'(bus.sprite_rgb), 32'h654321);
      bus.pac_moving = 1'b1;
      repeat (ANIM - 1) cyc(1, 0, 0, 0);
      cyc(1, 1, 105, 103);
      cyc(0, 1, 105, 103);
      check("anim_coincident_old", 32'(bus.sprite_rgb), 32'h654321);
      cyc(0, 0, 0, 0);
      check("anim_new_state", 32'(bus.sprite_rgb), 32'h123456);

      // Right-edge boundary without wrap
      place(620, 100, 400, 300, 450, 300, 500, 300);
      rom_pc[10'h153] = 24'hABCDEF;
      bus.DrawX = 10'd639; bus.DrawY = 10'd110; #1;
      check("edge_addr", 32'(bus.pac_addr), 32'h153);
      cyc(0, 1, 639, 110);
      cyc(0, 1, 3, 110);
      check("edge_hit", 32'(bus.sprite_hit), 32'd1);
      cyc(0, 1, 652, 110);
      check("nowrap_hit", 32'(bus.sprite_hit), 32'd0);
      cyc(0, 0, 0, 0);
      check("past_edge_hit", 32'(bus.sprite_hit), 32'd0);

      // Mid-stream reset
      place(150, 150, 160, 150, 150, 160, 170, 170);
      for (int i = 0; i < 4; i++) cyc(0, 1, 150 + 3 * i, 155 + i);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(bus.px_valid_out), 32'd0);
      check("mid_rst_hit",   32'(bus.sprite_hit),   32'd0);
      check("mid_rst_rgb",   32'(bus.sprite_rgb),   32'd0);
      bus.px_valid_in = 1'b0;
      bus.frame_start = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 6; i++) cyc(0, 1, 160 + 2 * i, 165 + i);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         int sel, bx, by;
         if (n % 40 == 0)
            place($urandom_range(80, 620), $urandom_range(80, 440), $urandom_range(80, 620),
                  $urandom_range(80, 440), $urandom_range(80, 620), $urandom_range(80, 440),
                  $urandom_range(80, 620), $urandom_range(80, 440));
         if (n % 50 == 0) bus.pac_moving = ($urandom_range(0, 7) != 0);
         bus.pac_dir    = 2'($urandom);
         bus.frightened = 1'($urandom);
         sel = $urandom_range(0, 4);
         case (sel)
            0: begin bx = int'(bus.red_x);   by = int'(bus.red_y);   end
            1: begin bx = int'(bus.blue_x);  by = int'(bus.blue_y);  end
            2: begin bx = int'(bus.green_x); by = int'(bus.green_y); end
            3: begin bx = int'(bus.pac_x);   by = int'(bus.pac_y);   end
            default: begin bx = $urandom_range(0, 600); by = $urandom_range(0, 440); end
         endcase
         cyc($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
             bx + $urandom_range(0, 39) - 4, by + $urandom_range(0, 39) - 4);
      end
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
